// File: rtl/foc_pkg.sv
// foc_pkg: shared types and constants for the FOC loop scheduler.
// Scheduler states and PID coefficient indices.
package foc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CFG,
    LAUNCH,
    WAIT
  } state_t;

  localparam int N_COEF = 3;

  localparam logic [1:0] COEF_P = 2'd0;
  localparam logic [1:0] COEF_I = 2'd1;
  localparam logic [1:0] COEF_D = 2'd2;

endpackage

// File: rtl/pid_coef_shadow.sv
// pid_coef_shadow: one PID bank's staged coefficients and pending bits.
// Presents the lowest-index pending entry for write-out.
module pid_coef_shadow #(
  parameter int D_WIDTH = 19,
  parameter int N_COEF  = 3
) (
  input  logic               clk,
  input  logic               rstb,
  input  logic               stage_wen,
  input  logic [1:0]         stage_addr,
  input  logic [D_WIDTH-1:0] stage_data,
  input  logic               drain,
  output logic               any_pend,
  output logic [1:0]         sel_addr,
  output logic [D_WIDTH-1:0] sel_data
);

  logic [D_WIDTH-1:0] coef [N_COEF];
  logic [N_COEF-1:0]  pend;
  logic               stage_hit;

  assign stage_hit = stage_wen && (int'(stage_addr) < N_COEF);
  assign any_pend  = |pend;

  // descending scan so the lowest pending index wins
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = N_COEF - 1; i >= 0; i--) begin
      if (pend[i]) begin
        sel_addr = 2'(i);
        sel_data = coef[i];
      end
    end
  end

  // a fresh stage beats the drain, so a same-cycle rewrite stays pending
  always_ff @(posedge clk or posedge rstb) begin
    if (rstb) begin
      pend <= '0;
      for (int i = 0; i < N_COEF; i++) coef[i] <= '0;
    end else begin
      for (int i = 0; i < N_COEF; i++) begin
        if (stage_hit && int'(stage_addr) == i) begin
          coef[i] <= stage_data;
          pend[i] <= 1'b1;
        end else if (drain && pend[i] && int'(sel_addr) == i) begin
          pend[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/foc_loop_scheduler.sv
// foc_loop_scheduler: per-PWM-period sequencer for the FOC datapath.
// Ticks, samples inputs, launches, loads PID banks, counts faults.
module foc_loop_scheduler #(
  parameter int D_WIDTH    = 19,
  parameter int N_COEF     = foc_pkg::N_COEF,
  parameter int VALID_HOLD = 4,
  parameter int TIMEOUT    = 4096
) (
  input  logic               clk,
  input  logic               rstb,
  input  logic               enable,
  input  logic [D_WIDTH-1:0] period_top,
  input  logic [D_WIDTH-1:0] angle_raw,
  input  logic [D_WIDTH-1:0] currA_raw,
  input  logic [D_WIDTH-1:0] currB_raw,
  output logic [D_WIDTH-1:0] angle_in,
  output logic [D_WIDTH-1:0] currA_in,
  output logic [D_WIDTH-1:0] currB_in,
  output logic               valid,
  input  logic               ready,
  input  logic               cfg_wen,
  input  logic               cfg_bank,
  input  logic [1:0]         cfg_addr,
  input  logic [D_WIDTH-1:0] cfg_data,
  output logic               pid_d_wen,
  output logic               pid_q_wen,
  output logic [D_WIDTH-1:0] pid_d_addr,
  output logic [D_WIDTH-1:0] pid_q_addr,
  output logic [D_WIDTH-1:0] pid_d_data,
  output logic [D_WIDTH-1:0] pid_q_data,
  output logic               busy,
  output logic [15:0]        overrun_cnt,
  output logic [15:0]        timeout_cnt
);

  import foc_pkg::*;

  localparam int SW = $clog2(TIMEOUT + VALID_HOLD) + 1;

  state_t             state, state_nx;
  logic [D_WIDTH-1:0] cnt;
  logic [SW-1:0]      step_cnt;
  logic               run, tick, tick_pend;
  logic               ready_q, rise;
  logic               launch, tmo;
  logic               d_any, q_any, cfg_pend, drain;
  logic [1:0]         d_sel, q_sel;
  logic [D_WIDTH-1:0] d_dat, q_dat;

  assign run  = enable && (period_top != '0);
  // >= also covers period_top shrinking below the running count
  assign tick = run && (cnt >= period_top - D_WIDTH'(1));
  assign rise = ready && !ready_q;

  always_ff @(posedge clk or posedge rstb) begin
    if (rstb) cnt <= '0;
    else if (!run || tick) cnt <= '0;
    else cnt <= cnt + D_WIDTH'(1);
  end

  assign drain    = (state == CFG);
  assign cfg_pend = d_any || q_any;

  pid_coef_shadow #(.D_WIDTH(D_WIDTH), .N_COEF(N_COEF)) u_d (
    .clk(clk), .rstb(rstb),
    .stage_wen(cfg_wen && !cfg_bank),
    .stage_addr(cfg_addr), .stage_data(cfg_data),
    .drain(drain), .any_pend(d_any),
    .sel_addr(d_sel), .sel_data(d_dat)
  );

  pid_coef_shadow #(.D_WIDTH(D_WIDTH), .N_COEF(N_COEF)) u_q (
    .clk(clk), .rstb(rstb),
    .stage_wen(cfg_wen && cfg_bank),
    .stage_addr(cfg_addr), .stage_data(cfg_data),
    .drain(drain), .any_pend(q_any),
    .sel_addr(q_sel), .sel_data(q_dat)
  );

  always_comb begin
    state_nx = state;
    launch   = 1'b0;
    tmo      = 1'b0;
    unique case (state)
      IDLE: begin
        if (cfg_pend) begin
          state_nx = CFG;
        end else if (tick || tick_pend) begin
          state_nx = LAUNCH;
          launch   = 1'b1;
        end
      end
      CFG: begin
        if (!cfg_pend) state_nx = IDLE;
      end
      LAUNCH: begin
        if (step_cnt == SW'(VALID_HOLD - 1)) state_nx = WAIT;
      end
      WAIT: begin
        if (rise) begin
          state_nx = IDLE;
        end else if (step_cnt == SW'(TIMEOUT - 1)) begin
          state_nx = IDLE;
          tmo      = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rstb) begin
    if (rstb) begin
      state    <= IDLE;
      step_cnt <= '0;
      ready_q  <= 1'b0;
    end else begin
      state   <= state_nx;
      ready_q <= ready;
      if (state_nx != state || state == IDLE || state == CFG)
        step_cnt <= '0;
      else
        step_cnt <= step_cnt + SW'(1);
    end
  end

  // ticks landing while config drains are replayed, not dropped
  always_ff @(posedge clk or posedge rstb) begin
    if (rstb) begin
      tick_pend <= 1'b0;
    end else if (launch) begin
      tick_pend <= 1'b0;
    end else if (tick && (state == CFG || (state == IDLE && cfg_pend))) begin
      tick_pend <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rstb) begin
    if (rstb) begin
      angle_in <= '0;
      currA_in <= '0;
      currB_in <= '0;
    end else if (launch) begin
      angle_in <= angle_raw;
      currA_in <= currA_raw;
      currB_in <= currB_raw;
    end
  end

  always_ff @(posedge clk or posedge rstb) begin
    if (rstb) begin
      overrun_cnt <= '0;
      timeout_cnt <= '0;
    end else begin
      if (tick && (state == LAUNCH || state == WAIT) && overrun_cnt != 16'hFFFF)
        overrun_cnt <= overrun_cnt + 16'd1;
      if (tmo && timeout_cnt != 16'hFFFF)
        timeout_cnt <= timeout_cnt + 16'd1;
    end
  end

  assign valid      = (state == LAUNCH);
  assign busy       = (state != IDLE);
  assign pid_d_wen  = drain && d_any;
  assign pid_q_wen  = drain && q_any;
  assign pid_d_addr = pid_d_wen ? D_WIDTH'(d_sel) : '0;
  assign pid_q_addr = pid_q_wen ? D_WIDTH'(q_sel) : '0;
  assign pid_d_data = pid_d_wen ? d_dat : '0;
  assign pid_q_data = pid_q_wen ? q_dat : '0;

endmodule
